mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single RAM/memory-mapped I/O bus (one-hot mem_cmd, 9-bit mem_addr, 16-bit data) between requester 0 (cpu) and requester 1 (loader/debug port).
- Sits between the requesters and the RAM plus I/O decode. It sequences each access over a fixed 2-cycle window so that the RAM's 1-cycle registered read data is captured cleanly.
- Grants are round-robin when both requesters contend.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM/I/O side.
// slave: arbiter view; master: requester + memory environment view.
interface mem_arbiter_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 16
);
    logic          req0;
    logic [2:0]    cmd0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic [2:0]    cmd1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata1;

    logic [2:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  req0, cmd0, addr0, wdata0,
        input  req1, cmd1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_cmd, mem_addr, mem_wdata,
        output busy, owner
    );

    modport master (
        output req0, cmd0, addr0, wdata0,
        output req1, cmd1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_cmd, mem_addr, mem_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter for the shared RAM / memory-mapped I/O bus.
// Each access runs IDLE -> ACCESS -> DONE; ack and read data land together after DONE.
module mem_arbiter #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [2:0] MNONE  = 3'b001;
    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q;
    logic          owner_q;
    logic          busy_q;
    logic          rd_q;
    logic [2:0]    mem_cmd_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          ack0_q;
    logic          ack1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          req_any_c;
    logic          gnt_port_c;
    logic [2:0]    gnt_cmd_c;
    logic [AW-1:0] gnt_addr_c;
    logic [DW-1:0] gnt_wdata_c;
    logic          gnt_cmd_ok_c;

    // Contention goes to the port that did not own the bus last.
    always_comb begin
        req_any_c = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            gnt_port_c = ~owner_q;
        end else begin
            gnt_port_c = bus.req1;
        end
        gnt_cmd_c    = gnt_port_c ? bus.cmd1   : bus.cmd0;
        gnt_addr_c   = gnt_port_c ? bus.addr1  : bus.addr0;
        gnt_wdata_c  = gnt_port_c ? bus.wdata1 : bus.wdata0;
        gnt_cmd_ok_c = (gnt_cmd_c == MREAD) || (gnt_cmd_c == MWRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b1;
            busy_q      <= 1'b0;
            rd_q        <= 1'b0;
            mem_cmd_q   <= MNONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    mem_cmd_q <= MNONE;
                    if (req_any_c) begin
                        state_q     <= ACCESS;
                        busy_q      <= 1'b1;
                        owner_q     <= gnt_port_c;
                        // Unsupported commands still run the window but never reach the bus.
                        mem_cmd_q   <= gnt_cmd_ok_c ? gnt_cmd_c : MNONE;
                        mem_addr_q  <= gnt_addr_c;
                        mem_wdata_q <= gnt_wdata_c;
                        rd_q        <= (gnt_cmd_c == MREAD);
                    end
                end
                ACCESS: begin
                    state_q   <= DONE;
                    mem_cmd_q <= MNONE;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    // RAM read data registered at the end of ACCESS is stable here.
                    if (owner_q) begin
                        ack1_q <= 1'b1;
                        if (rd_q) begin
                            rdata1_q <= bus.mem_rdata;
                        end
                    end else begin
                        ack0_q <= 1'b1;
                        if (rd_q) begin
                            rdata0_q <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    mem_cmd_q <= MNONE;
                end
            endcase
        end
    end

    assign bus.mem_cmd   = mem_cmd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed timing cases plus two randomized
// requesters checked against a transaction-level memory model.
module tb_mem_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    localparam logic [2:0] MNONE  = 3'b001;
    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;

    typedef struct packed {
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_rd  [2];
    bit            ram_ready = 1'b0;
    bus_t          bus_q[$];

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pattern(input int i);
        return 16'(i * 37 + 32'h5A00);
    endfunction

    function automatic logic [DW-1:0] io_rd(input logic [AW-1:0] a);
        return (a == 9'h140) ? 16'h00A5 : {7'h55, a};
    endfunction

    // RAM with one-cycle registered read, plus an external I/O read mux.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= pattern(i);
            ram_ready <= 1'b1;
        end else if (bus.mem_cmd == MWRITE && !bus.mem_addr[8]) begin
            ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        bus.mem_rdata <= bus.mem_addr[8] ? io_rd(bus.mem_addr) : ram[bus.mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus monitor: command legality every cycle, and a log of every real bus access.
    always @(negedge clk) begin
        chk("mem_cmd_legal",
            32'(bus.mem_cmd == MNONE || bus.mem_cmd == MREAD || bus.mem_cmd == MWRITE), 32'd1);
        if (bus.mem_cmd != MNONE) bus_q.push_back('{bus.mem_cmd, bus.mem_addr, bus.mem_wdata});
    end

    function automatic logic [2:0] exp_bus(input logic [2:0] c);
        return (c == MREAD || c == MWRITE) ? c : MNONE;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return a[8] ? io_rd(a) : ref_mem[a[7:0]];
    endfunction

    function automatic logic ack_of(input int p);
        return (p == 0) ? bus.ack0 : bus.ack1;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input int p);
        return (p == 0) ? bus.rdata0 : bus.rdata1;
    endfunction

    // Completed access in program order: reads return memory, writes update it.
    task automatic model_apply(input int p, input logic [2:0] c, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
        if (c == MREAD) exp_rd[p] = model_read(a);
        else if (c == MWRITE && !a[8]) ref_mem[a[7:0]] = d;
    endtask

    task automatic drive(input int p, input logic r, input logic [2:0] c,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.cmd0 = c; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.cmd1 = c; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic set_req(input int p, input logic r);
        if (p == 0) bus.req0 = r;
        else bus.req1 = r;
    endtask

    // One uncontended access with cycle-exact checks; chg alters inputs after grant.
    task automatic do_single(input int p, input logic [2:0] c, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit chg);
        int o = 1 - p;
        drive(p, 1'b1, c, a, d);
        @(negedge clk);
        chk("acc_mem_cmd", 32'(bus.mem_cmd), 32'(exp_bus(c)));
        chk("acc_mem_addr", 32'(bus.mem_addr), 32'(a));
        if (c == MWRITE) chk("acc_mem_wdata", 32'(bus.mem_wdata), 32'(d));
        chk("acc_busy", 32'(bus.busy), 32'd1);
        chk("acc_owner", 32'(bus.owner), 32'(p));
        chk("acc_no_ack", 32'(bus.ack0 | bus.ack1), 32'd0);
        if (chg) drive(p, 1'b0, c, a ^ 9'h010, ~d);
        @(negedge clk);
        chk("done_mem_cmd", 32'(bus.mem_cmd), 32'(MNONE));
        chk("done_mem_addr", 32'(bus.mem_addr), 32'(a));
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_no_ack", 32'(bus.ack0 | bus.ack1), 32'd0);
        @(negedge clk);
        model_apply(p, c, a, d);
        chk("ack_own", 32'(ack_of(p)), 32'd1);
        chk("ack_other", 32'(ack_of(o)), 32'd0);
        chk("ack_rdata_own", 32'(rdata_of(p)), 32'(exp_rd[p]));
        chk("ack_rdata_other", 32'(rdata_of(o)), 32'(exp_rd[o]));
        chk("ack_busy", 32'(bus.busy), 32'd0);
        chk("ack_mem_addr_hold", 32'(bus.mem_addr), 32'(a));
        set_req(p, 1'b0);
        @(negedge clk);
        chk("ack_once", 32'(ack_of(p)), 32'd0);
    endtask

    task automatic rand_port(input int p, input int n);
        logic [2:0]    c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            r, w, gap;
        bit            got;
        bus_t          e;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            c = (r < 4) ? MREAD : (r < 8) ? MWRITE : (r == 8) ? MNONE : 3'b011;
            a = ($urandom_range(0, 3) == 0) ? 9'($urandom) : {5'b0, 4'($urandom)};
            d = 16'($urandom);
            drive(p, 1'b1, c, a, d);
            got = 1'b0;
            w   = 0;
            while (!got && w < 12) begin
                @(negedge clk);
                w++;
                if (ack_of(p)) got = 1'b1;
            end
            // Round-robin bounds any wait to one foreign access plus our own.
            chk($sformatf("rnd_p%0d_latency", p), 32'(got && (w <= 6)), 32'd1);
            if (!got) begin
                set_req(p, 1'b0);
                return;
            end
            model_apply(p, c, a, d);
            chk("rnd_rdata", 32'(rdata_of(p)), 32'(exp_rd[p]));
            chk("rnd_other_ack", 32'(ack_of(1 - p)), 32'd0);
            if (exp_bus(c) != MNONE) begin
                chk("rnd_bus_count", 32'(bus_q.size()), 32'd1);
                if (bus_q.size() > 0) begin
                    e = bus_q.pop_front();
                    chk("rnd_bus_cmd", 32'(e.cmd), 32'(c));
                    chk("rnd_bus_addr", 32'(e.addr), 32'(a));
                    if (c == MWRITE) chk("rnd_bus_wdata", 32'(e.wdata), 32'(d));
                end
            end else begin
                chk("rnd_bus_count", 32'(bus_q.size()), 32'd0);
            end
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                set_req(p, 1'b0);
                repeat (gap) @(negedge clk);
            end
        end
        set_req(p, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n_acks;
        int unsigned last;
        int          p;

        for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        drive(0, 1'b0, MNONE, '0, '0);
        drive(1, 1'b0, MNONE, '0, '0);
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_mem_cmd", 32'(bus.mem_cmd), 32'(MNONE));
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd1);
        chk("rst_acks", 32'(bus.ack0 | bus.ack1), 32'd0);
        chk("rst_rdata0", 32'(bus.rdata0), 32'd0);
        chk("rst_rdata1", 32'(bus.rdata1), 32'd0);
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_mem_cmd", 32'(bus.mem_cmd), 32'(MNONE));
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_acks", 32'(bus.ack0 | bus.ack1), 32'd0);
        end

        do_single(0, MWRITE, 9'h005, 16'hABCD, 1'b0);
        do_single(0, MREAD,  9'h005, 16'h0000, 1'b0);
        chk("rd_0x005_value", 32'(bus.rdata0), 32'h0000ABCD);
        do_single(1, MREAD,  9'h140, 16'h0000, 1'b0);
        chk("io_rd_0x140", 32'(bus.rdata1), 32'h000000A5);
        do_single(1, MWRITE, 9'h100, 16'h0033, 1'b0);
        do_single(0, MREAD,  9'h020, 16'h0000, 1'b1);
        do_single(0, MNONE,  9'h021, 16'h1111, 1'b0);
        do_single(0, 3'b011, 9'h022, 16'h2222, 1'b0);

        // Reset during ACCESS aborts the write and produces no ack.
        drive(0, 1'b1, MWRITE, 9'h050, 16'hDEAD);
        @(negedge clk);
        chk("abort_pre_cmd", 32'(bus.mem_cmd), 32'(MWRITE));
        #2 reset = 1'b0;
        #1;
        chk("abort_mem_cmd", 32'(bus.mem_cmd), 32'(MNONE));
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_owner", 32'(bus.owner), 32'd1);
        chk("abort_acks", 32'(bus.ack0 | bus.ack1), 32'd0);
        set_req(0, 1'b0);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(bus.ack0 | bus.ack1), 32'd0);
        end
        do_single(0, MREAD, 9'h050, 16'h0000, 1'b0);

        // Both ports reading continuously from reset alternate strictly.
        reset = 1'b0;
        drive(0, 1'b1, MREAD, 9'h010, '0);
        drive(1, 1'b1, MREAD, 9'h011, '0);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        @(negedge clk);
        reset  = 1'b1;
        n_acks = 0;
        last   = 0;
        for (int c = 0; c < 60 && n_acks < 10; c++) begin
            @(negedge clk);
            chk("rr_single_ack", 32'(bus.ack0 & bus.ack1), 32'd0);
            if (bus.ack0 || bus.ack1) begin
                p = bus.ack1 ? 1 : 0;
                chk("rr_order", 32'(p), 32'(n_acks % 2));
                if (n_acks > 0) chk("rr_spacing", cyc - last, 32'd3);
                exp_rd[p] = model_read((p == 0) ? 9'h010 : 9'h011);
                chk("rr_rdata", 32'(rdata_of(p)), 32'(exp_rd[p]));
                last = cyc;
                n_acks++;
                if (n_acks == 10) begin
                    set_req(0, 1'b0);
                    set_req(1, 1'b0);
                end
            end
        end
        chk("rr_count", 32'(n_acks), 32'd10);
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        repeat (2) @(negedge clk);
        chk("rr_idle_busy", 32'(bus.busy), 32'd0);

        bus_q.delete();
        fork
            rand_port(0, 120);
            rand_port(1, 120);
        join
        repeat (4) @(negedge clk);
        chk("end_busy", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
